muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multicycle sequencer for the signed MULT/DIV path that feeds the HI/LO registers.
//  Runs a radix-2 Booth multiplier or a restoring divider one iteration per clock.
//  Exposes a start/busy/done handshake to ControlUnit, which stalls in its wait state until done.
//  Drives WriteHI/WriteLO plus the Hi/Lo data for MuxHI/MuxLO.
// PARAMETERS
//  WIDTH  32  operand width; the product is 2*WIDTH (Hi:Lo)
// PORTS
//  clock    in   1      system clock, rising edge
//  reset    in   1      asynchronous, active-low reset
//  start    in   1      request; sampled only in IDLE
//  Op       in   1      0 = MULT (signed), 1 = DIV (signed)
//  OpA      in   WIDTH  multiplicand / dividend (RegA)
//  OpB      in   WIDTH  multiplier / divisor (RegB)
//  busy     out  1      high from the cycle after start is accepted until done
//  done     out  1      one-cycle completion pulse
//  DivZero  out  1      one-cycle pulse with done when DIV has OpB==0
//  Hi       out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
//  Lo       out  WIDTH  MULT: product[W-1:0]; DIV: quotient
//  WriteHI  out  1      load strobe for the HI register; equal to done & ~DivZero
//  WriteLO  out  1      load strobe for the LO register; equal to done & ~DivZero
// BEHAVIOUR
//  Reset (async, reset==0):
//   - State goes to IDLE; the iteration counter clears.
//   - All outputs go to 0, including Hi and Lo.
//  States: IDLE, MULT, DIV, FIX, DONE.
//  Capture:
//   - Condition: IDLE and start==1 at a rising edge.
//   - OpA, OpB and Op are latched; counter = 0.
//   - Next state is MULT, or DIV.
//   - Exception: if Op==1 and OpB==0, next state is DONE with a pending DivZero.
//  start in any non-IDLE state is ignored. It is not queued.
//  Operands are not re-sampled after capture; OpA and OpB may change freely.
//  MULT:
//   - Booth step each cycle: examine {P[0],q_-1}, add/sub the multiplicand in upper half.
//   - Arithmetic shift right 1. Counter++.
//   - After WIDTH iterations, go to DONE.
//  DIV:
//   - Operate on the magnitudes |OpA| and |OpB|, as unsigned WIDTH-bit values.
//   - One restoring shift/subtract step per cycle, for WIDTH iterations; then go to FIX.
//  FIX (DIV only, 1 cycle):
//   - Negate the quotient if sign(OpA) != sign(OpB).
//   - Negate the remainder if OpA < 0.
//   - Quotient truncates toward zero; remainder takes the sign of the dividend.
//   - Arithmetic is mod 2^WIDTH: 0x80000000 / -1 gives Lo=0x80000000, Hi=0. It raises no flag.
//  DONE (1 cycle):
//   - done=1; busy=0; next state IDLE.
//   - Hi and Lo hold the result from DONE until the next accepted start.
//   - On DivZero: WriteHI=WriteLO=0 and Hi/Lo keep their previous values.
//  Latency, counted from the accepting edge to the cycle with done=1:
//   - MULT: WIDTH+1 cycles (33 at the default).
//   - DIV: WIDTH+2 cycles (34 at the default).
//   - DIV by zero: 1 cycle.
//  A new start can be accepted at the first edge after DONE, once back in IDLE.
//  Reset mid-operation aborts immediately. No write strobes are produced.
// TESTING
//  - MULT 3 x -2 (0x00000003, 0xFFFFFFFE):
//    Hi=0xFFFFFFFF, Lo=0xFFFFFFFA. done and WriteHI/WriteLO pulse exactly 33 cycles after start.
//  - MULT 0x7FFFFFFF x 0x7FFFFFFF:
//    Hi=0x3FFFFFFF, Lo=0x00000001. Also check 0x80000000 x 0x80000000 gives Hi=0x40000000, Lo=0.
//  - DIV -7 / 2:
//    Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1), done at cycle 34.
//    Also check 7 / -2 gives Lo=-3, Hi=1.
//  - DIV 7 / 0:
//    done and DivZero pulse 1 cycle after start; WriteHI=WriteLO=0; Hi/Lo unchanged.
//    Also check 0x80000000 / -1 gives Lo=0x80000000, Hi=0.
//  - Handshake:
//    start held high for 40 cycles gives exactly one done per accepted request.
//    A second start pulsed during busy is ignored.
//    Back-to-back request accepted the edge after DONE.
//  - Reset mid-operation:
//    Assert reset at iteration 10 of a MULT. Outputs go to 0 asynchronously; no WriteHI/WriteLO.
//    After release, a new MULT 5 x 6 gives Lo=30, Hi=0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multicycle signed MULT/DIV engine feeding the HI/LO registers.
// A radix-2 Booth multiplier or a restoring divider runs one iteration per clock.
// Ports:
//   clock, reset    rising-edge clock, asynchronous active-low reset
//   start, Op       request (sampled only in IDLE); 0 = MULT, 1 = DIV (both signed)
//   OpA, OpB        multiplicand/dividend, multiplier/divisor (captured on accept)
//   busy            high while iterating or fixing up signs
//   done            one-cycle completion pulse
//   DivZero         pulses with done when a DIV had a zero divisor
//   Hi, Lo          MULT: product high/low; DIV: remainder/quotient
//   WriteHI/WriteLO HI/LO load strobes (done without DivZero)
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             busy,
  output logic             done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             WriteHI,
  output logic             WriteLO
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StMult, StDiv, StFix, StDone} state_e;

  state_e state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // acc: Booth upper half (one guard bit so the most negative multiplicand
  // cannot overflow) or the divider's partial remainder.
  logic [WIDTH:0]   acc_q, acc_d;
  // q: Booth multiplier/lower product half, or dividend shifting into quotient.
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  // m: multiplicand, or divisor magnitude.
  logic [WIDTH-1:0] m_q, m_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] rem_lo;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    mag_a     = OpA[WIDTH-1] ? -OpA : OpA;
    mag_b     = OpB[WIDTH-1] ? -OpB : OpB;
    rem_lo    = acc_q[WIDTH-1:0];

    m_ext     = {m_q[WIDTH-1], m_q};
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase

    div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, m_q});

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d = '0;
          acc_d = '0;
          qm1_d = 1'b0;
          dz_d  = 1'b0;
          if (Op) begin
            q_d    = mag_a;
            m_d    = mag_b;
            qneg_d = OpA[WIDTH-1] ^ OpB[WIDTH-1];
            rneg_d = OpA[WIDTH-1];
            if (OpB == '0) begin
              dz_d    = 1'b1;
              state_d = StDone;
            end else begin
              state_d = StDiv;
            end
          end else begin
            q_d     = OpB;
            m_d     = OpA;
            state_d = StMult;
          end
        end
      end
      StMult: begin
        // Arithmetic shift right of {acc, q, q_-1} after the Booth add/sub.
        acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastIter) begin
          hi_d    = acc_d[WIDTH-1:0];
          lo_d    = q_d;
          state_d = StDone;
        end
      end
      StDiv: begin
        acc_d = div_ge ? (div_shift - {1'b0, m_q}) : div_shift;
        q_d   = {q_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastIter) begin
          state_d = StFix;
        end
      end
      StFix: begin
        lo_d    = qneg_q ? -q_q : q_q;
        hi_d    = rneg_q ? -rem_lo : rem_lo;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy    = (state_q == StMult) || (state_q == StDiv) || (state_q == StFix);
  assign done    = (state_q == StDone);
  assign DivZero = done & dz_q;
  assign WriteHI = done & ~dz_q;
  assign WriteLO = done & ~dz_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: table-driven directed vectors, hand-written handshake/reset
// sequences and randomized operations checked against a longint arithmetic model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         start;
  logic         Op;
  logic [W-1:0] OpA;
  logic [W-1:0] OpB;
  logic         busy;
  logic         done;
  logic         DivZero;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;
  logic         WriteHI;
  logic         WriteLO;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .Op      (Op),
    .OpA     (OpA),
    .OpB     (OpB),
    .busy    (busy),
    .done    (done),
    .DivZero (DivZero),
    .Hi      (Hi),
    .Lo      (Lo),
    .WriteHI (WriteHI),
    .WriteLO (WriteLO)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [W-1:0] prev_hi = '0;
  logic [W-1:0] prev_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Reference model: plain 64-bit signed arithmetic.
  task automatic model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] ehi, output logic [W-1:0] elo,
                       output logic edz, output int elat);
    longint la, lb, p, qq, rr;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    edz = 1'b0;
    if (!op) begin
      p    = la * lb;
      ehi  = p[63:32];
      elo  = p[31:0];
      elat = W + 1;
    end else if (b == '0) begin
      edz  = 1'b1;
      ehi  = prev_hi;
      elo  = prev_lo;
      elat = 1;
    end else begin
      qq   = la / lb;
      rr   = la % lb;
      ehi  = rr[31:0];
      elo  = qq[31:0];
      elat = W + 2;
    end
  endtask

  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string name, input int elat, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input logic edz);
    int n;
    @(negedge clock);
    start = 1'b1; Op = op; OpA = a; OpB = b;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    OpA = $urandom;
    OpB = $urandom;
    n = 1;
    check({name, " busy"}, {63'd0, busy}, {63'd0, ~edz});
    while (!done && n < 100) begin
      @(posedge clock);
      @(negedge clock);
      n++;
    end
    check({name, " done"}, {63'd0, done}, 64'd1);
    check({name, " latency"}, 64'(n), 64'(elat));
    check({name, " Hi"}, {32'd0, Hi}, {32'd0, ehi});
    check({name, " Lo"}, {32'd0, Lo}, {32'd0, elo});
    check({name, " DivZero"}, {63'd0, DivZero}, {63'd0, edz});
    check({name, " WriteHI/LO"}, {62'd0, WriteHI, WriteLO}, {62'd0, ~edz, ~edz});
    @(negedge clock);
    check({name, " done pulse"}, {63'd0, done}, 64'd0);
    if (!edz) begin
      prev_hi = ehi;
      prev_lo = elo;
    end
  endtask

  typedef struct {
    string        name;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rhi, rlo, ra, rb;
    logic         rdz, rop;
    int           rlat, dones, first_c, second_c, n, wr;

    vecs[0] = '{"mul 3x-2",   1'b0, 32'h00000003, 32'hFFFFFFFE, 33, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
    vecs[1] = '{"mul max",    1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 33, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[2] = '{"mul min",    1'b0, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h00000000, 1'b0};
    vecs[3] = '{"div -7/2",   1'b1, 32'hFFFFFFF9, 32'h00000002, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4] = '{"div 7/-2",   1'b1, 32'h00000007, 32'hFFFFFFFE, 34, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[5] = '{"div 7/0",    1'b1, 32'h00000007, 32'h00000000, 1,  32'h00000001, 32'hFFFFFFFD, 1'b1};
    vecs[6] = '{"div min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000, 1'b0};

    reset = 1'b1; start = 1'b0; Op = 1'b0; OpA = '0; OpB = '0;
    #3 reset = 1'b0;
    #1;
    check("reset busy/done/dz", {61'd0, busy, done, DivZero}, 64'd0);
    check("reset Hi/Lo", {Hi, Lo}, 64'd0);
    check("reset WriteHI/LO", {62'd0, WriteHI, WriteLO}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].name, vecs[i].lat,
             vecs[i].hi, vecs[i].lo, vecs[i].dz);
    end

    // start held for 40 edges: accepted at edge 1 and again at edge 35.
    @(negedge clock);
    start = 1'b1; Op = 1'b0; OpA = 32'd5; OpB = 32'd6;
    dones = 0; first_c = -1; second_c = -1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (c == 40) start = 1'b0;
      if (done) begin
        dones++;
        if (first_c < 0) first_c = c;
        else if (second_c < 0) second_c = c;
        check("held start Lo", {32'd0, Lo}, 64'd30);
      end
    end
    check("held start done count", 64'(dones), 64'd2);
    check("held start first done", 64'(first_c), 64'd33);
    check("back-to-back gap", 64'(second_c - first_c), 64'd34);
    prev_hi = '0; prev_lo = 32'd30;

    // A start pulsed while busy must be neither honoured nor queued.
    @(negedge clock);
    start = 1'b1; Op = 1'b0; OpA = 32'd3; OpB = 32'd4;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      @(posedge clock);
      @(negedge clock);
      n++;
      if (n == 10) begin start = 1'b1; Op = 1'b1; OpA = 32'd100; OpB = 32'd0; end
      if (n == 11) start = 1'b0;
    end
    check("ignored start latency", 64'(n), 64'd33);
    check("ignored start Lo", {32'd0, Lo}, 64'd12);
    check("ignored start Hi", {32'd0, Hi}, 64'd0);
    check("ignored start DivZero", {63'd0, DivZero}, 64'd0);
    dones = 0;
    repeat (50) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("ignored start not queued", 64'(dones), 64'd0);
    prev_hi = '0; prev_lo = 32'd12;

    for (int i = 0; i < 20; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 3));
        1: ra = 32'h80000000;
        default: ;
      endcase
      model(rop, ra, rb, rhi, rlo, rdz, rlat);
      run_op(rop, ra, rb, $sformatf("rand%0d %s %h,%h", i, rop ? "div" : "mul", ra, rb),
             rlat, rhi, rlo, rdz);
    end

    // Reset at about iteration 10 of a MULT aborts it with no write strobes.
    @(negedge clock);
    start = 1'b1; Op = 1'b0; OpA = 32'h00012345; OpB = 32'h00000777;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("abort busy/done", {62'd0, busy, done}, 64'd0);
    check("abort Hi/Lo", {Hi, Lo}, 64'd0);
    check("abort WriteHI/LO", {62'd0, WriteHI, WriteLO}, 64'd0);
    wr = 0;
    repeat (3) begin
      @(negedge clock);
      if (WriteHI || WriteLO || done) wr++;
    end
    reset = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (WriteHI || WriteLO || done) wr++;
    end
    check("abort no strobes", 64'(wr), 64'd0);
    prev_hi = '0; prev_lo = '0;
    run_op(1'b0, 32'd5, 32'd6, "mul 5x6 after reset", 33, 32'd0, 32'd30, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
